// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM command encodings, timing defaults and idle bus values
//
// Purpose: common definitions for the SDRAM controller stages (init, auto-refresh, arbiter).
// Ports:   none (package).

package sdram_pkg;

   // {CS#, RAS#, CAS#, WE#}
   localparam logic [3:0] CMD_NOP       = 4'b0111;
   localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
   localparam logic [3:0] CMD_AT_REF    = 4'b0001;
   localparam logic [3:0] CMD_MREG_SET  = 4'b0000;
   localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
   localparam logic [3:0] CMD_READ      = 4'b0101;
   localparam logic [3:0] CMD_WRITE     = 4'b0100;

   // Default timing, in clocks at 100 MHz
   localparam int TRP_DEF  = 2;
   localparam int TRFC_DEF = 8;
   localparam int TMRD_DEF = 2;

   // Bus values when no command needs them; A10=1 also selects all banks for PRECHARGE
   localparam logic [1:0]  IDLE_BANK = 2'b11;
   localparam logic [12:0] IDLE_ADDR = 13'h1fff;

   // Gray-coded so every legal transition flips a single state bit
   typedef enum logic [2:0] {
      AREF_IDLE = 3'b000,
      AREF_PCH  = 3'b001,
      AREF_TRP  = 3'b011,
      AREF_AR   = 3'b010,
      AREF_TRFC = 3'b110,
      AREF_END  = 3'b100
   } aref_state_t;

endpackage

// File: rtl/sdram_aref_timer.sv
// rtl/sdram_aref_timer.sv - refresh interval counter and refresh request flag
//
// Purpose: counts REF_PERIOD clocks while init_end is high and raises a level
//          request each time the interval expires; the request drops when the
//          grant is accepted.
// Ports:
//   aref_clk   in  clock
//   aref_rst_n in  synchronous active-low reset
//   init_end   in  initialisation complete (level); low holds counter and request at 0
//   grant      in  grant accepted this cycle (from the refresh FSM)
//   aref_req   out refresh request (level)

module sdram_aref_timer #(
   parameter int REF_PERIOD = 750
) (
   input  logic aref_clk,
   input  logic aref_rst_n,
   input  logic init_end,
   input  logic grant,
   output logic aref_req
);

   localparam int CNT_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

   logic [CNT_W-1:0] ref_cnt;
   logic             expire;

   assign expire = (ref_cnt == CNT_W'(REF_PERIOD - 1));

   // Free-running through refresh sequences so the period is fixed, not grant-relative
   always_ff @(posedge aref_clk) begin
      if (!aref_rst_n) begin
         ref_cnt <= '0;
      end else if (!init_end || expire) begin
         ref_cnt <= '0;
      end else begin
         ref_cnt <= ref_cnt + 1'b1;
      end
   end

   // Set wins over clear; a second expiry while pending just keeps the single request
   always_ff @(posedge aref_clk) begin
      if (!aref_rst_n) begin
         aref_req <= 1'b0;
      end else if (!init_end) begin
         aref_req <= 1'b0;
      end else if (expire) begin
         aref_req <= 1'b1;
      end else if (grant) begin
         aref_req <= 1'b0;
      end
   end

endmodule

// File: rtl/sdram_aref.sv
// rtl/sdram_aref.sv - periodic SDRAM auto-refresh generator
//
// Purpose: after init_end, requests a refresh every REF_PERIOD clocks; on grant
//          issues PRECHARGE-all, then AR_NUM AUTO REFRESH commands spaced by
//          TRP/TRFC, then pulses aref_end for one cycle.
// Ports:
//   aref_clk   in  1   clock (100 MHz)
//   aref_rst_n in  1   synchronous active-low reset
//   init_end   in  1   initialisation complete (level)
//   aref_en    in  1   arbiter grant (level)
//   aref_req   out 1   refresh request (level)
//   aref_cmd   out 4   {CS#,RAS#,CAS#,WE#}
//   aref_bank  out 2   bank address
//   aref_addr  out 13  SDRAM address
//   aref_end   out 1   sequence-complete pulse

import sdram_pkg::*;

module sdram_aref #(
   parameter int REF_PERIOD = 750,
   parameter int TRP        = TRP_DEF,
   parameter int TRFC       = TRFC_DEF,
   parameter int AR_NUM     = 2
) (
   input  logic        aref_clk,
   input  logic        aref_rst_n,
   input  logic        init_end,
   input  logic        aref_en,
   output logic        aref_req,
   output logic [3:0]  aref_cmd,
   output logic [1:0]  aref_bank,
   output logic [12:0] aref_addr,
   output logic        aref_end
);

   localparam int WAIT_MAX = (TRP > TRFC) ? TRP : TRFC;
   localparam int CYC_W    = $clog2(WAIT_MAX + 1);
   localparam int AR_W     = $clog2(AR_NUM + 1);

   aref_state_t      state;
   aref_state_t      state_nxt;
   logic [CYC_W-1:0] cyc_cnt;
   logic [AR_W-1:0]  ar_cnt;
   logic             grant;

   // aref_en outside IDLE or without a pending request is ignored
   assign grant = aref_req && aref_en && (state == AREF_IDLE);

   sdram_aref_timer #(
      .REF_PERIOD (REF_PERIOD)
   ) u_timer (
      .aref_clk   (aref_clk),
      .aref_rst_n (aref_rst_n),
      .init_end   (init_end),
      .grant      (grant),
      .aref_req   (aref_req)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         AREF_IDLE: if (grant) state_nxt = AREF_PCH;
         AREF_PCH:  state_nxt = AREF_TRP;
         AREF_TRP:  if (cyc_cnt == CYC_W'(TRP - 1)) state_nxt = AREF_AR;
         AREF_AR:   state_nxt = AREF_TRFC;
         AREF_TRFC: begin
            if (cyc_cnt == CYC_W'(TRFC - 1)) begin
               state_nxt = (ar_cnt < AR_W'(AR_NUM)) ? AREF_AR : AREF_END;
            end
         end
         AREF_END:  state_nxt = AREF_IDLE;
         default:   state_nxt = AREF_IDLE;
      endcase
   end

   // cyc_cnt is zero outside the wait states, so it starts from 0 on every entry
   always_ff @(posedge aref_clk) begin
      if (!aref_rst_n) begin
         state   <= AREF_IDLE;
         cyc_cnt <= '0;
         ar_cnt  <= '0;
      end else begin
         state <= state_nxt;

         if (state == AREF_TRP || state == AREF_TRFC) begin
            cyc_cnt <= cyc_cnt + 1'b1;
         end else begin
            cyc_cnt <= '0;
         end

         if (state == AREF_IDLE) begin
            ar_cnt <= '0;
         end else if (state == AREF_AR) begin
            ar_cnt <= ar_cnt + 1'b1;
         end
      end
   end

   // Outputs are decoded from the current state and registered, so they trail it by a clock
   always_ff @(posedge aref_clk) begin
      if (!aref_rst_n) begin
         aref_cmd  <= CMD_NOP;
         aref_bank <= IDLE_BANK;
         aref_addr <= IDLE_ADDR;
         aref_end  <= 1'b0;
      end else begin
         aref_bank <= IDLE_BANK;
         aref_addr <= IDLE_ADDR;
         aref_end  <= (state == AREF_END);
         case (state)
            AREF_PCH: aref_cmd <= CMD_PRECHARGE;
            AREF_AR:  aref_cmd <= CMD_AT_REF;
            default:  aref_cmd <= CMD_NOP;
         endcase
      end
   end

endmodule
